// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - shared types, field positions and phase lengths for the MDIO master
package mdio_pkg;

  typedef enum logic [2:0] {IDLE, PRE, HDR, WR, TA_RD, RD, END} state_t;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  // t_data field positions
  localparam int ST_MSB    = 31;
  localparam int OP_MSB    = 29;
  localparam int OP_LSB    = 28;
  localparam int PHYAD_MSB = 27;
  localparam int REGAD_MSB = 22;
  localparam int TA_MSB    = 17;
  localparam int DATA_MSB  = 15;

  // bit periods per frame phase
  localparam int HDR_BITS = 14;
  localparam int WR_BITS  = 18;
  localparam int RD_BITS  = 16;
  localparam int TA_BITS  = 2;

  // last bit index of a phase, in bit counter width
  function automatic logic [5:0] last_idx(input int n);
    return 6'(n - 1);
  endfunction

endpackage

// File: rtl/mdc_gen.sv
// rtl/mdc_gen.sv - MDC divider with period-start and sample-point strobes
module mdc_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic mdc,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int CW = $clog2(DIV) + 1;

  logic [CW-1:0] cnt;
  logic          half_end;

  // last clk of a half period: the next edge toggles mdc
  assign half_end = en && (cnt == CW'(DIV - 1));
  assign rise_stb = half_end && !mdc;
  assign fall_stb = half_end && mdc;

  // half-period counter; disabled generator parks mdc low at phase start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else if (half_end) begin
      cnt <= '0;
      mdc <= ~mdc;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mdio_controller.sv
// rtl/mdio_controller.sv - Clause-22 MDIO station master: preamble, frame shift-out, read capture
module mdio_controller import mdio_pkg::*; #(
  parameter int DIV     = 1,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdio_start,
  input  logic [31:0] t_data,
  input  logic        mdio_in,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic [15:0] rd_data,
  output logic        data_rdy,
  output logic        busy
);

  state_t      state, state_n;
  logic [5:0]  bit_cnt;
  logic [5:0]  last;
  logic [31:0] frame;
  logic        is_read;
  logic [15:0] rd_shift;
  logic        active;
  logic        fall_stb;
  logic        rise_stb;
  logic        done;

  // MDC runs only while a frame is on the wire
  assign active = (state != IDLE) && (state != END);
  assign busy   = active;

  mdc_gen #(.DIV(DIV)) u_mdc_gen (
    .clk      (clk),
    .rst_n    (reset),
    .en       (active),
    .mdc      (mdc),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  // phase length lookup and end-of-phase detect at a period boundary
  always_comb begin
    last = '0;
    case (state)
      PRE:     last = last_idx(PRE_LEN);
      HDR:     last = last_idx(HDR_BITS);
      WR:      last = last_idx(WR_BITS);
      TA_RD:   last = last_idx(TA_BITS);
      RD:      last = last_idx(RD_BITS);
      default: last = '0;
    endcase
    done = fall_stb && (bit_cnt == last);
  end

  // next state and pad/handshake outputs
  always_comb begin
    state_n  = state;
    mdio_oe  = 1'b0;
    mdio_out = 1'b0;
    data_rdy = 1'b0;
    case (state)
      IDLE:  if (mdio_start) state_n = PRE;
      PRE: begin
        mdio_oe  = 1'b1;
        mdio_out = 1'b1;
        if (done) state_n = HDR;
      end
      HDR: begin
        mdio_oe  = 1'b1;
        mdio_out = frame[31];
        if (done) state_n = is_read ? TA_RD : WR;
      end
      WR: begin
        mdio_oe  = 1'b1;
        mdio_out = frame[31];
        if (done) state_n = END;
      end
      TA_RD: if (done) state_n = RD;
      RD:    if (done) state_n = END;
      END: begin
        data_rdy = is_read;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // state, frame shifter, bit counter and read capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      frame    <= '0;
      is_read  <= 1'b0;
      rd_shift <= '0;
      rd_data  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && mdio_start) begin
        frame   <= t_data;
        is_read <= (t_data[OP_MSB:OP_LSB] == OP_READ);
        bit_cnt <= '0;
      end
      if (fall_stb) begin
        bit_cnt <= (state_n != state) ? 6'd0 : bit_cnt + 6'd1;
        if (state == HDR || state == WR) frame <= {frame[30:0], 1'b0};
      end
      if (rise_stb && state == RD) rd_shift <= {rd_shift[14:0], mdio_in};
      if (state == RD && state_n == END) rd_data <= rd_shift;
    end
  end

endmodule

// File: tb/tb_mdio_controller.sv
// tb/tb_mdio_controller.sv - randomized self-checking bench with a cycle-level frame model
module tb_mdio_controller;

  localparam int PRE = 32;

  logic        clk = 1'b0;
  logic        rst[2];
  logic        start[2];
  logic [31:0] td[2];
  logic        min[2];
  logic        mdc[2], mo[2], oe[2], rdy[2], bsy[2];
  logic [15:0] rdd[2];

  // model state: k = clk index inside the current frame (1..flen, flen+1 = END), -1 idle
  int          k[2];
  logic [31:0] mf[2];
  logic [15:0] rv[2], pn[2], er[2];
  int          bcnt[2], rcnt[2], rat[2], scyc[2];
  int          cyc = 0;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  mdio_controller #(.DIV(1), .PRE_LEN(PRE)) dut0 (
    .clk(clk), .reset(rst[0]), .mdio_start(start[0]), .t_data(td[0]), .mdio_in(min[0]),
    .mdc(mdc[0]), .mdio_out(mo[0]), .mdio_oe(oe[0]), .rd_data(rdd[0]), .data_rdy(rdy[0]), .busy(bsy[0]));

  mdio_controller #(.DIV(3), .PRE_LEN(PRE)) dut1 (
    .clk(clk), .reset(rst[1]), .mdio_start(start[1]), .t_data(td[1]), .mdio_in(min[1]),
    .mdc(mdc[1]), .mdio_out(mo[1]), .mdio_oe(oe[1]), .rd_data(rdd[1]), .data_rdy(rdy[1]), .busy(bsy[1]));

  function automatic int divof(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int flen(input int i);
    return (PRE + 32) * 2 * divof(i);
  endfunction

  function automatic logic is_rd(input logic [31:0] f);
    return f[29:28] == 2'b10;
  endfunction

  // wire bit of period b: preamble ones, then the frame MSB first
  function automatic logic ebit(input logic [31:0] f, input int b);
    if (b < PRE) return 1'b1;
    return f[31 - (b - PRE)];
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %h want %h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // frame-level reference: acceptance, progress, END and rd_data update
  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst[i]) begin
        k[i]  = -1;
        er[i] = 16'h0;
      end else if (k[i] < 0) begin
        if (start[i]) begin
          k[i] = 1; mf[i] = td[i]; rv[i] = pn[i]; scyc[i] = cyc;
        end
      end else if (k[i] == flen(i) + 1) begin
        k[i] = -1;
      end else begin
        k[i]++;
        if (k[i] == flen(i) + 1 && is_rd(mf[i])) er[i] = rv[i];
      end
    end
  end

  // per-cycle compare plus PHY drive of mdio_in
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int   kk, d, b, p;
      logic em, eo, ev, eb, erd, co;
      kk = k[i]; d = divof(i); b = 0; p = 0;
      em = 1'b0; eo = 1'b0; ev = 1'b0; eb = 1'b0; erd = 1'b0; co = !rst[i];
      if (rst[i] && kk > 0 && kk <= flen(i)) begin
        b  = (kk - 1) / (2 * d);
        p  = (kk - 1) % (2 * d);
        em = (p >= d);
        eb = 1'b1;
        eo = !(is_rd(mf[i]) && b >= PRE + 14);
        ev = eo ? ebit(mf[i], b) : 1'b0;
        co = eo;
      end else if (rst[i] && kk == flen(i) + 1) begin
        erd = is_rd(mf[i]);
        co  = 1'b1;
      end
      chk("mdc", i, 32'(mdc[i]), 32'(em));
      chk("mdio_oe", i, 32'(oe[i]), 32'(eo));
      chk("busy", i, 32'(bsy[i]), 32'(eb));
      chk("data_rdy", i, 32'(rdy[i]), 32'(erd));
      chk("rd_data", i, 32'(rdd[i]), 32'(er[i]));
      if (co) chk("mdio_out", i, 32'(mo[i]), 32'(ev));
      if (bsy[i]) bcnt[i]++;
      if (rdy[i]) begin
        rcnt[i]++;
        rat[i] = cyc - scyc[i];
      end
      if (rst[i] && kk > 0 && kk <= flen(i) && is_rd(mf[i]) && b >= PRE + 16)
        min[i] = rv[i][15 - (b - PRE - 16)];
      else
        min[i] = 1'($urandom);
    end
  end

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while ((k[i] >= 0 || bsy[i]) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", i, 32'(n < 4000), 32'd1);
  endtask

  task automatic run_frame(input int i, input logic [31:0] d, input logic [15:0] phy);
    @(negedge clk);
    td[i] = d; pn[i] = phy; start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    wait_idle(i);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, r0, n;
    logic [31:0] d;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; start[i] = 1'b0; td[i] = '0; pn[i] = '0; k[i] = -1;
      mf[i] = '0; rv[i] = '0; er[i] = '0; bcnt[i] = 0; rcnt[i] = 0; rat[i] = 0; scyc[i] = 0;
      min[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_mdc", i, 32'(mdc[i]), 32'd0);
      chk("rst_oe", i, 32'(oe[i]), 32'd0);
      chk("rst_out", i, 32'(mo[i]), 32'd0);
      chk("rst_busy", i, 32'(bsy[i]), 32'd0);
      chk("rst_rdy", i, 32'(rdy[i]), 32'd0);
      chk("rst_rd_data", i, 32'(rdd[i]), 32'd0);
    end
    @(negedge clk); #2;
    rst[0] = 1'b1; rst[1] = 1'b1;
    repeat (4) @(negedge clk);

    // write frame: busy for exactly 128 clk, no data_rdy
    b0 = bcnt[0]; r0 = rcnt[0];
    run_frame(0, 32'h5192BEEF, 16'h0000);
    chk("wr_busy_clks", 0, 32'(bcnt[0] - b0), 32'd128);
    chk("wr_no_rdy", 0, 32'(rcnt[0] - r0), 32'd0);

    // read frame: PHY returns A5C3, one data_rdy 128 edges after the accepting edge
    r0 = rcnt[0];
    run_frame(0, 32'h61900000, 16'hA5C3);
    chk("rd_value", 0, 32'(rdd[0]), 32'h0000A5C3);
    chk("rd_rdy_count", 0, 32'(rcnt[0] - r0), 32'd1);
    chk("rd_rdy_time", 0, 32'(rat[0]), 32'd128);

    // start re-pulsed mid-frame with other data must be ignored
    @(negedge clk);
    td[0] = 32'h61900000; pn[0] = 16'h1234; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (60) @(negedge clk);
    td[0] = 32'h50000000; pn[0] = 16'hFFFF; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_idle(0);
    chk("repulse_rd", 0, 32'(rdd[0]), 32'h00001234);

    // asynchronous reset during the read data phase
    r0 = rcnt[0];
    @(negedge clk);
    td[0] = 32'h61900000; pn[0] = 16'h8001; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n = 0;
    while (k[0] < 110 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reach_rd_phase", 0, 32'(n < 500), 32'd1);
    #2 rst[0] = 1'b0;
    #1;
    chk("arst_busy", 0, 32'(bsy[0]), 32'd0);
    chk("arst_mdc", 0, 32'(mdc[0]), 32'd0);
    chk("arst_oe", 0, 32'(oe[0]), 32'd0);
    chk("arst_out", 0, 32'(mo[0]), 32'd0);
    chk("arst_rd_data", 0, 32'(rdd[0]), 32'd0);
    repeat (3) @(negedge clk);
    #2 rst[0] = 1'b1;
    run_frame(0, 32'h61900000, 16'h0F0F);
    chk("post_rst_rd", 0, 32'(rdd[0]), 32'h00000F0F);
    chk("post_rst_rdy", 0, 32'(rcnt[0] - r0), 32'd1);

    // randomized frames, any opcode
    for (int t = 0; t < 12; t++) begin
      d = $urandom;
      if ($urandom_range(0, 1) == 1) d[29:28] = 2'b10;
      run_frame(0, d, 16'($urandom));
    end

    // DIV=3: start held high, second frame accepted right after END + IDLE
    r0 = rcnt[1];
    @(negedge clk);
    td[1] = 32'h6A5A0000; pn[1] = 16'h3C96; start[1] = 1'b1;
    @(negedge clk);
    td[1] = 32'h5ABCDEF0; pn[1] = 16'hC3A5;
    n = 0;
    while (k[1] != flen(1) + 1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_reach_end", 1, 32'(n < 1000), 32'd1);
    chk("b2b_end_busy", 1, 32'(bsy[1]), 32'd0);
    chk("b2b_end_rd", 1, 32'(rdd[1]), 32'h00003C96);
    @(negedge clk);
    chk("b2b_idle_busy", 1, 32'(bsy[1]), 32'd0);
    @(negedge clk);
    chk("b2b_second_busy", 1, 32'(bsy[1]), 32'd1);
    start[1] = 1'b0;
    wait_idle(1);
    chk("b2b_rdy_count", 1, 32'(rcnt[1] - r0), 32'd1);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
